// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_IDLE  = 1'b1
   } rf_state_e;
endpackage

// File: rtl/regfile_mp_if.sv
// Read ports, write port, clear request and status of the register file.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     clr;
   logic                     ready;
   logic                     wr_drop;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, clr,
      input  rd_data, ready, wr_drop
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, clr,
      output rd_data, ready, wr_drop
   );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sweep controller: owns state, sweep pointer and ready.
// One entry zeroed per cycle; a clear request restarts the sweep from entry 0.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              sweep_en,
   output logic [ADDR_W-1:0] sweep_addr,
   output logic              ready
);
   localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

   rf_state_e         state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RF_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      unique case (state)
         RF_CLEAR: begin
            if (clr) begin
               ptr_nxt = '0;
            end else if (ptr == LAST) begin
               state_nxt = RF_IDLE;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt = ptr + 1'b1;
            end
         end
         RF_IDLE: begin
            if (clr) begin
               state_nxt = RF_CLEAR;
               ptr_nxt   = '0;
            end
         end
         default: begin
            state_nxt = RF_CLEAR;
            ptr_nxt   = '0;
         end
      endcase
   end

   // ready comes straight off the state flop, so it is glitch-free
   assign ready      = (state == RF_IDLE);
   assign sweep_en   = (state == RF_CLEAR);
   assign sweep_addr = ptr;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass, optional zero register
// and a hardware clear sweep; reads are combinational, writes land on the clock edge.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]        mem [DEPTH];
   logic                     sweep_en;
   logic [ADDR_W-1:0]        sweep_addr;
   logic                     user_we;
   logic                     drop_q;
   logic [NUM_RD*DATA_W-1:0] rd_all;

   regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (bus.clr),
      .sweep_en   (sweep_en),
      .sweep_addr (sweep_addr),
      .ready      (bus.ready)
   );

   // zero-register writes vanish quietly; they are not reported as drops
   assign user_we = !sweep_en && bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

   always_ff @(posedge clk) begin
      if (sweep_en) begin
         mem[sweep_addr] <= '0;
      end else if (user_we) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= sweep_en && bus.wr_en;
      end
   end

   assign bus.wr_drop = drop_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         data = '0;
         if (sweep_en) begin
            data = '0;
         end else if (ZERO_REG && (addr == '0)) begin
            data = '0;
         end else if (bus.wr_en && (bus.wr_addr == addr)) begin
            data = bus.wr_data;
         end else begin
            data = mem[addr];
         end
      end

      assign rd_all[k*DATA_W +: DATA_W] = data;
   end

   assign bus.rd_data = rd_all;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a default build (2 ports, zero register) and a 4-port build without it.
module tb_regfile_mp;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus1 ();

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b0)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
      bus0.wr_en   = en;
      bus0.wr_addr = addr;
      bus0.wr_data = data;
      bus1.wr_en   = en;
      bus1.wr_addr = addr;
      bus1.wr_data = data;
   endtask

   function automatic logic [31:0] p0(input int k);
      return bus0.rd_data[k*32 +: 32];
   endfunction

   function automatic logic [31:0] p1(input int k);
      return bus1.rd_data[k*32 +: 32];
   endfunction

   initial begin
      rst_n        = 1'b0;
      bus0.rd_addr = '0;
      bus1.rd_addr = '0;
      bus0.clr     = 1'b0;
      bus1.clr     = 1'b0;
      drive_wr(1'b0, 5'd0, 32'h0);

      // reset state
      edge1();
      edge1();
      chk("rst_ready0", {31'b0, bus0.ready}, 32'd0);
      chk("rst_drop0", {31'b0, bus0.wr_drop}, 32'd0);
      chk("rst_ready1", {31'b0, bus1.ready}, 32'd0);

      // ready rises on the 32nd edge after release
      rst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         edge1();
         chk($sformatf("sweep_ready_e%0d", i), {31'b0, bus0.ready}, {31'b0, (i == 32)});
      end
      chk("sweep_ready1", {31'b0, bus1.ready}, 32'd1);

      // whole array swept to zero
      for (int a = 0; a < 32; a++) begin
         bus0.rd_addr = {5'(31 - a), 5'(a)};
         bus1.rd_addr = {5'(a), 5'(a), 5'(a), 5'(31 - a)};
         #1;
         chk($sformatf("clr0_p0_a%0d", a), p0(0), 32'h0);
         chk($sformatf("clr0_p1_a%0d", a), p0(1), 32'h0);
         chk($sformatf("clr1_p3_a%0d", a), p1(3), 32'h0);
      end

      // same-cycle bypass, then array readback
      bus0.rd_addr = {5'd0, 5'd5};
      bus1.rd_addr = {5'd0, 5'd0, 5'd0, 5'd5};
      drive_wr(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      chk("byp_p0", p0(0), 32'hDEADBEEF);
      chk("byp_dut1", p1(0), 32'hDEADBEEF);
      edge1();
      drive_wr(1'b0, 5'd0, 32'h0);
      #1;
      chk("arr_p0", p0(0), 32'hDEADBEEF);
      chk("arr_drop", {31'b0, bus0.wr_drop}, 32'd0);

      // zero register vs plain entry 0
      bus0.rd_addr = {5'd0, 5'd0};
      bus1.rd_addr = {5'd0, 5'd0, 5'd0, 5'd0};
      drive_wr(1'b1, 5'd0, 32'h12345678);
      #1;
      chk("zr_byp0", p0(0), 32'h0);
      chk("zr_byp1", p1(0), 32'h12345678);
      edge1();
      drive_wr(1'b0, 5'd0, 32'h0);
      #1;
      chk("zr_rd0_p0", p0(0), 32'h0);
      chk("zr_rd0_p1", p0(1), 32'h0);
      chk("zr_drop0", {31'b0, bus0.wr_drop}, 32'd0);
      chk("zr_rd1", p1(2), 32'h12345678);

      // fill two more entries
      drive_wr(1'b1, 5'd3, 32'hA5A5A5A5);
      edge1();
      drive_wr(1'b1, 5'd9, 32'h00001111);
      edge1();
      drive_wr(1'b0, 5'd0, 32'h0);

      // four independent ports, plus two ports on one entry
      bus1.rd_addr = {5'd9, 5'd3, 5'd0, 5'd5};
      bus0.rd_addr = {5'd3, 5'd3};
      #1;
      chk("mp_p0", p1(0), 32'hDEADBEEF);
      chk("mp_p1", p1(1), 32'h12345678);
      chk("mp_p2", p1(2), 32'hA5A5A5A5);
      chk("mp_p3", p1(3), 32'h00001111);
      chk("same_p0", p0(0), 32'hA5A5A5A5);
      chk("same_p1", p0(1), 32'hA5A5A5A5);

      // clear from IDLE with a same-cycle write that is performed, not dropped
      bus0.clr = 1'b1;
      bus1.clr = 1'b1;
      drive_wr(1'b1, 5'd12, 32'hCAFE0000);
      edge1();
      bus0.clr = 1'b0;
      bus1.clr = 1'b0;
      chk("clr_ready_fall", {31'b0, bus0.ready}, 32'd0);
      chk("clr_no_drop", {31'b0, bus0.wr_drop}, 32'd0);

      // write during CLEAR is dropped and reported one cycle later
      bus0.rd_addr = {5'd7, 5'd3};
      drive_wr(1'b1, 5'd7, 32'h00000001);
      #1;
      chk("clr_rd_zero", p0(1), 32'h0);
      chk("clr_rd3_zero", p0(0), 32'h0);
      edge1();
      drive_wr(1'b0, 5'd0, 32'h0);
      chk("drop_pulse", {31'b0, bus0.wr_drop}, 32'd1);
      edge1();
      chk("drop_end", {31'b0, bus0.wr_drop}, 32'd0);
      for (int i = 3; i <= 32; i++) begin
         edge1();
         chk($sformatf("clr_ready_e%0d", i), {31'b0, bus0.ready}, {31'b0, (i == 32)});
      end

      bus0.rd_addr = {5'd7, 5'd3};
      bus1.rd_addr = {5'd12, 5'd9, 5'd0, 5'd5};
      #1;
      chk("post_clr_a3", p0(0), 32'h0);
      chk("post_clr_a7", p0(1), 32'h0);
      chk("post_clr1_a5", p1(0), 32'h0);
      chk("post_clr1_a0", p1(1), 32'h0);
      chk("post_clr1_a9", p1(2), 32'h0);
      chk("post_clr1_a12", p1(3), 32'h0);

      // reset ten cycles into a sweep restarts the full sweep
      drive_wr(1'b1, 5'd4, 32'h44444444);
      edge1();
      drive_wr(1'b0, 5'd0, 32'h0);
      bus0.clr = 1'b1;
      bus1.clr = 1'b1;
      edge1();
      bus0.clr = 1'b0;
      bus1.clr = 1'b0;
      for (int i = 0; i < 10; i++) edge1();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'b0, bus0.ready}, 32'd0);
      chk("mid_rst_drop", {31'b0, bus0.wr_drop}, 32'd0);
      edge1();
      edge1();
      rst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         edge1();
         chk($sformatf("rst2_ready_e%0d", i), {31'b0, bus1.ready}, {31'b0, (i == 32)});
      end
      bus0.rd_addr = {5'd4, 5'd4};
      #1;
      chk("rst2_a4", p0(0), 32'h0);
      chk("rst2_ready0", {31'b0, bus0.ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
